// File: rtl/exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// exec_stage_pkg
// Shared widths, ALU operation encoding and pipeline register layouts for the
// execute / memory / write-back stage and its ALU.
// -----------------------------------------------------------------------------
package exec_stage_pkg;

  localparam int DATA_W  = 32;  // datapath width
  localparam int ADRX_W  = 5;   // register address width
  localparam int SHORT_W = 9;   // width of the jump-register target slice
  localparam int IMM_W   = 16;  // decode immediate width
  localparam int CTL_W   = 4;   // ALU control width

  // ALU operation encoding; codes 9..15 are unused and yield 0.
  typedef enum logic [CTL_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_PASSB = 4'd8
  } alu_op_e;

  // Contents of the exec pipeline register (one cycle after decode).
  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [DATA_W-1:0]  store_data;
    logic [ADRX_W-1:0]  wr_adrx;
    logic               write_en;
    logic               is_load;
    logic               dmem_write;
    logic               z_flag;
    logic [SHORT_W-1:0] rd_data0_short;
  } exec_reg_t;

  // Contents of the write-back pipeline register (two cycles after decode).
  typedef struct packed {
    logic [ADRX_W-1:0] wr_adrx;
    logic [DATA_W-1:0] wr_data;
    logic              write_en;
  } wb_reg_t;

  // Sign-extend the 16-bit decode immediate to the datapath width.
  function automatic logic [DATA_W-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/exec_stage_if.sv
// -----------------------------------------------------------------------------
// exec_stage_if
// Bus between the control unit / register file / data memory (master side)
// and the execute stage (slave side).
//   master drives : flush, decode* control, rfRdData0/1, dmemRdData
//   slave drives  : dmemAdrx, dmemWrData, dmemWrite, execZFlag,
//                   execRfRdData0Short, wbRfWrAdrx, wbRfWrData, wbRfWriteEn,
//                   hazardStall
// -----------------------------------------------------------------------------
interface exec_stage_if;
  import exec_stage_pkg::*;

  // Decode-stage register bank and squash request
  logic                flush;
  logic [ADRX_W-1:0]   decodeRfRdAdrx0;
  logic [ADRX_W-1:0]   decodeRfRdAdrx1;
  logic [ADRX_W-1:0]   decodeRfWrAdrx;
  logic [CTL_W-1:0]    decodeAluCtl;
  logic                decodeRfWriteEn;
  logic                decodeAluBusBSel;
  logic                decodeDmemResultSel;
  logic                decodeDmemWrite;
  logic [IMM_W-1:0]    decodeImmediate;
  logic                decodeRegDest;

  // Register file and data memory read data
  logic [DATA_W-1:0]   rfRdData0;
  logic [DATA_W-1:0]   rfRdData1;
  logic [DATA_W-1:0]   dmemRdData;

  // Data memory access
  logic [DATA_W-1:0]   dmemAdrx;
  logic [DATA_W-1:0]   dmemWrData;
  logic                dmemWrite;

  // Next-PC feedback
  logic                execZFlag;
  logic [SHORT_W-1:0]  execRfRdData0Short;

  // Register file write-back and stall
  logic [ADRX_W-1:0]   wbRfWrAdrx;
  logic [DATA_W-1:0]   wbRfWrData;
  logic                wbRfWriteEn;
  logic                hazardStall;

  modport master (
    output flush, decodeRfRdAdrx0, decodeRfRdAdrx1, decodeRfWrAdrx, decodeAluCtl,
           decodeRfWriteEn, decodeAluBusBSel, decodeDmemResultSel, decodeDmemWrite,
           decodeImmediate, decodeRegDest, rfRdData0, rfRdData1, dmemRdData,
    input  dmemAdrx, dmemWrData, dmemWrite, execZFlag, execRfRdData0Short,
           wbRfWrAdrx, wbRfWrData, wbRfWriteEn, hazardStall
  );

  modport slave (
    input  flush, decodeRfRdAdrx0, decodeRfRdAdrx1, decodeRfWrAdrx, decodeAluCtl,
           decodeRfWriteEn, decodeAluBusBSel, decodeDmemResultSel, decodeDmemWrite,
           decodeImmediate, decodeRegDest, rfRdData0, rfRdData1, dmemRdData,
    output dmemAdrx, dmemWrData, dmemWrite, execZFlag, execRfRdData0Short,
           wbRfWrAdrx, wbRfWrData, wbRfWriteEn, hazardStall
  );

endinterface

// File: rtl/exec_stage_alu.sv
// -----------------------------------------------------------------------------
// exec_stage_alu
// Purely combinational ALU.
//   a, b    : operands
//   ctl     : operation (alu_op_e), unused codes give 0
//   result  : operation result, wraps modulo 2^DATA_W
//   zero    : result == 0
// -----------------------------------------------------------------------------
module exec_stage_alu
  import exec_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTL_W-1:0]  ctl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [4:0] shamt_s;

  assign shamt_s = b[4:0];

  // Operation decode and evaluation
  always_comb begin
    result = '0;
    case (alu_op_e'(ctl))
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT: begin
        if ($signed(a) < $signed(b)) begin
          result = {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
          result = '0;
        end
      end
      ALU_SLL:   result = a << shamt_s;
      ALU_SRL:   result = a >> shamt_s;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_stage.sv
// -----------------------------------------------------------------------------
// exec_stage
// Execute / memory / write-back stage fed by the decode register bank.
//   clk    : all state updates on the rising edge
//   reset  : synchronous, active-high; clears exec and wb registers
//   bus    : exec_stage_if slave port (decode controls, register file and
//            data memory data, write-back, next-PC feedback, hazardStall)
// Operands are forwarded from the exec and wb registers, the ALU result and
// store data are registered in the exec register, and the wb register selects
// between the ALU result and load data for register-file write-back.
// -----------------------------------------------------------------------------
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  exec_stage_if.slave bus
);

  exec_reg_t         exec_d, exec_q;
  wb_reg_t           wb_d, wb_q;

  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] store_data_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              alu_zero_s;
  logic [ADRX_W-1:0] dest_adrx_s;
  logic              uses_b_s;
  logic              hazard_s;
  logic              bubble_s;

  // Newest producer wins: exec reg (unless it is a load, whose data is not
  // back yet), then wb reg, then the register file. r0 is hard-wired to 0.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [ADRX_W-1:0] adrx,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_we,
    input logic              ex_is_load,
    input logic [ADRX_W-1:0] ex_adrx,
    input logic [DATA_W-1:0] ex_data,
    input logic              wb_we,
    input logic [ADRX_W-1:0] wb_adrx,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] val;
    if (adrx == '0) begin
      val = '0;
    end else if (ex_we && !ex_is_load && (ex_adrx == adrx)) begin
      val = ex_data;
    end else if (wb_we && (wb_adrx == adrx)) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // Operand forwarding, immediate selection and destination selection
  always_comb begin
    op_a_s = fwd_operand(bus.decodeRfRdAdrx0, bus.rfRdData0,
                         exec_q.write_en, exec_q.is_load, exec_q.wr_adrx, exec_q.result,
                         wb_q.write_en, wb_q.wr_adrx, wb_q.wr_data);
    store_data_s = fwd_operand(bus.decodeRfRdAdrx1, bus.rfRdData1,
                               exec_q.write_en, exec_q.is_load, exec_q.wr_adrx, exec_q.result,
                               wb_q.write_en, wb_q.wr_adrx, wb_q.wr_data);
    imm_ext_s = sign_extend_imm(bus.decodeImmediate);
    if (bus.decodeAluBusBSel) begin
      op_b_s = imm_ext_s;
    end else begin
      op_b_s = store_data_s;
    end
    if (bus.decodeRegDest) begin
      dest_adrx_s = bus.decodeRfWrAdrx;
    end else begin
      dest_adrx_s = bus.decodeRfRdAdrx1;
    end
  end

  exec_stage_alu u_alu (
    .a      (op_a_s),
    .b      (op_b_s),
    .ctl    (bus.decodeAluCtl),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  // Load-use detection: a load in the exec reg has no data to forward yet,
  // so any instruction reading its destination must wait one cycle.
  always_comb begin
    uses_b_s = !bus.decodeAluBusBSel || bus.decodeDmemWrite;
    hazard_s = 1'b0;
    if (exec_q.is_load && exec_q.write_en && (exec_q.wr_adrx != '0)) begin
      if (exec_q.wr_adrx == bus.decodeRfRdAdrx0) begin
        hazard_s = 1'b1;
      end else if (uses_b_s && (exec_q.wr_adrx == bus.decodeRfRdAdrx1)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = 1'b0;
      end
    end else begin
      hazard_s = 1'b0;
    end
    bubble_s = hazard_s || bus.flush;
  end

  // Exec register next state; a bubble kills every side effect but still
  // refreshes the next-PC feedback fields.
  always_comb begin
    exec_d                = '0;
    exec_d.result         = alu_result_s;
    exec_d.store_data     = store_data_s;
    exec_d.wr_adrx        = dest_adrx_s;
    exec_d.z_flag         = alu_zero_s;
    exec_d.rd_data0_short = op_a_s[SHORT_W-1:0];
    if (bubble_s) begin
      exec_d.write_en   = 1'b0;
      exec_d.is_load    = 1'b0;
      exec_d.dmem_write = 1'b0;
    end else begin
      exec_d.write_en   = bus.decodeRfWriteEn && (dest_adrx_s != '0);
      exec_d.is_load    = bus.decodeDmemResultSel;
      exec_d.dmem_write = bus.decodeDmemWrite;
    end
  end

  // Write-back register next state; dmem read data is asynchronous to the
  // exec-reg address, so load data is captured here.
  always_comb begin
    wb_d          = '0;
    wb_d.wr_adrx  = exec_q.wr_adrx;
    wb_d.write_en = exec_q.write_en;
    if (exec_q.is_load) begin
      wb_d.wr_data = bus.dmemRdData;
    end else begin
      wb_d.wr_data = exec_q.result;
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_q <= '0;
      wb_q   <= '0;
    end else begin
      exec_q <= exec_d;
      wb_q   <= wb_d;
    end
  end

  assign bus.dmemAdrx           = exec_q.result;
  assign bus.dmemWrData         = exec_q.store_data;
  assign bus.dmemWrite          = exec_q.dmem_write;
  assign bus.execZFlag          = exec_q.z_flag;
  assign bus.execRfRdData0Short = exec_q.rd_data0_short;
  assign bus.wbRfWrAdrx         = wb_q.wr_adrx;
  assign bus.wbRfWrData         = wb_q.wr_data;
  assign bus.wbRfWriteEn        = wb_q.write_en;
  assign bus.hazardStall        = hazard_s;

endmodule

// File: tb/tb_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_exec_stage
// Drives instructions into exec_stage through exec_stage_if and compares the
// results against an architectural (in-order, one-at-a-time) reference model.
// The bench also plays register file and data memory for the DUT.
// -----------------------------------------------------------------------------
module tb_exec_stage;
  import exec_stage_pkg::*;

  typedef struct {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [3:0]  ctl;
    logic        rdst;
    logic        bsel;
    logic        we;
    logic        ld;
    logic        st;
    logic [15:0] imm;
  } instr_t;

  typedef struct { logic [4:0]  adrx; logic [31:0] data; } wb_exp_t;
  typedef struct { logic [31:0] adrx; logic [31:0] data; } st_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] env_rf  [32] = '{default: 32'h0};
  logic [31:0] env_mem [64] = '{default: 32'h0};
  logic [31:0] ref_rf  [32] = '{default: 32'h0};
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  wb_exp_t     wb_exp [$];
  st_exp_t     st_exp [$];
  logic [4:0]  last_ld = 5'd0;   // dest of a load now sitting in the exec stage

  always #5 clk = ~clk;

  exec_stage_if bus();

  exec_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file and data memory seen by the DUT
  assign bus.rfRdData0  = env_rf[bus.decodeRfRdAdrx0];
  assign bus.rfRdData1  = env_rf[bus.decodeRfRdAdrx1];
  assign bus.dmemRdData = env_mem[bus.dmemAdrx[7:2]];

  always @(posedge clk) begin
    if (bus.wbRfWriteEn) env_rf[bus.wbRfWrAdrx] <= bus.wbRfWrData;
    if (bus.dmemWrite)   env_mem[bus.dmemAdrx[7:2]] <= bus.dmemWrData;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic instr_t mk(input logic [3:0] ctl, input logic [4:0] ra, input logic [4:0] rb,
                                input logic [4:0] rw, input logic rdst, input logic bsel,
                                input logic we, input logic ld, input logic st, input logic [15:0] imm);
    instr_t i;
    i.ctl = ctl; i.ra = ra; i.rb = rb; i.rw = rw; i.rdst = rdst;
    i.bsel = bsel; i.we = we; i.ld = ld; i.st = st; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t rr(input logic [3:0] ctl, input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
    return mk(ctl, ra, rb, rd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
  endfunction

  function automatic instr_t ri(input logic [3:0] ctl, input logic [4:0] rd, input logic [4:0] ra, input logic [15:0] imm);
    return mk(ctl, ra, rd, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, imm);
  endfunction

  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] ra, input logic [15:0] imm);
    return mk(4'd0, ra, rd, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, imm);
  endfunction

  function automatic instr_t sw(input logic [4:0] rs, input logic [4:0] ra, input logic [15:0] imm);
    return mk(4'd0, ra, rs, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, imm);
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int     kind;
    kind   = $urandom_range(0, 5);
    i.ra   = 5'($urandom_range(0, 7));
    i.rb   = 5'($urandom_range(0, 7));
    i.rw   = 5'($urandom_range(0, 7));
    i.ctl  = 4'($urandom_range(0, 15));
    i.rdst = 1'($urandom_range(0, 1));
    i.bsel = 1'($urandom_range(0, 1));
    i.we   = ($urandom_range(0, 7) != 0);
    i.ld   = 1'b0;
    i.st   = 1'b0;
    i.imm  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
    if (kind == 0) begin
      i = lw(i.rb, i.ra, 16'($urandom_range(0, 255)));
    end else if (kind == 1) begin
      i = sw(i.rb, i.ra, 16'($urandom_range(0, 255)));
    end
    return i;
  endfunction

  task automatic drive(input instr_t i, input logic fl);
    bus.flush               = fl;
    bus.decodeRfRdAdrx0     = i.ra;
    bus.decodeRfRdAdrx1     = i.rb;
    bus.decodeRfWrAdrx      = i.rw;
    bus.decodeAluCtl        = i.ctl;
    bus.decodeRfWriteEn     = i.we;
    bus.decodeAluBusBSel    = i.bsel;
    bus.decodeDmemResultSel = i.ld;
    bus.decodeDmemWrite     = i.st;
    bus.decodeImmediate     = i.imm;
    bus.decodeRegDest       = i.rdst;
  endtask

  // Present one instruction; re-present it while the model predicts a stall.
  // A flushed instruction is dropped. Leaves time at posedge + 1.
  task automatic step(input instr_t i, input logic fl, output int stalls);
    logic        exp_stall, issued, done;
    logic [31:0] a, bv, b, res, wv;
    logic [4:0]  dst, next_ld;
    stalls = 0;
    done   = 1'b0;
    while (!done) begin
      drive(i, fl);
      issued  = 1'b0;
      next_ld = 5'd0;
      a   = ref_rf[i.ra];
      bv  = ref_rf[i.rb];
      b   = i.bsel ? {{16{i.imm[15]}}, i.imm} : bv;
      res = ref_alu(i.ctl, a, b);
      dst = i.rdst ? i.rw : i.rb;
      @(negedge clk);
      exp_stall = (last_ld != 5'd0) &&
                  ((last_ld == i.ra) || ((!i.bsel || i.st) && (last_ld == i.rb)));
      check("hazard_stall", bus.hazardStall, exp_stall);
      if (fl) begin
        done = 1'b1;
      end else if (exp_stall) begin
        stalls++;
      end else begin
        issued = 1'b1;
        done   = 1'b1;
        if (i.st) begin
          st_exp.push_back('{res, bv});
          ref_mem[res[7:2]] = bv;
        end
        if (i.we && (dst != 5'd0)) begin
          wv = i.ld ? ref_mem[res[7:2]] : res;
          wb_exp.push_back('{dst, wv});
          ref_rf[dst] = wv;
          if (i.ld) next_ld = dst;
        end
      end
      @(posedge clk);
      #1;
      last_ld = next_ld;
      if (issued) begin
        check("exec_result", bus.dmemAdrx, res);
        check("exec_zflag", bus.execZFlag, (res == 32'd0));
        check("exec_short", bus.execRfRdData0Short, a[8:0]);
        check("exec_dmem_we", bus.dmemWrite, i.st);
      end else begin
        check("bubble_dmem_we", bus.dmemWrite, 1'b0);
      end
    end
  endtask

  // Write-back and store monitor against the model's expected order
  always @(negedge clk) begin
    if (bus.wbRfWriteEn) begin
      if (wb_exp.size() == 0) begin
        check("wb_spurious", bus.wbRfWriteEn, 1'b0);
      end else begin
        wb_exp_t e;
        e = wb_exp.pop_front();
        check("wb_adrx", bus.wbRfWrAdrx, e.adrx);
        check("wb_data", bus.wbRfWrData, e.data);
      end
    end
    if (bus.dmemWrite) begin
      if (st_exp.size() == 0) begin
        check("st_spurious", bus.dmemWrite, 1'b0);
      end else begin
        st_exp_t s;
        s = st_exp.pop_front();
        check("st_adrx", bus.dmemAdrx, s.adrx);
        check("st_data", bus.dmemWrData, s.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t nop;
    int     s;
    nop = mk(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(nop, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.dmemAdrx, bus.dmemWrData, bus.dmemWrite, bus.execZFlag,
                            bus.execRfRdData0Short, bus.wbRfWrAdrx, bus.wbRfWrData,
                            bus.wbRfWriteEn, bus.hazardStall}, 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back exec-stage forwarding
    step(ri(4'd0, 5'd1, 5'd0, 16'd5), 1'b0, s);
    step(rr(4'd0, 5'd2, 5'd1, 5'd1), 1'b0, s);
    check("fwd_exec_add", bus.dmemAdrx, 32'd10);

    // wb-stage forwarding
    step(ri(4'd0, 5'd3, 5'd0, 16'd7), 1'b0, s);
    step(ri(4'd0, 5'd13, 5'd0, 16'd1), 1'b0, s);
    step(rr(4'd1, 5'd4, 5'd3, 5'd3), 1'b0, s);
    check("fwd_wb_zflag", bus.execZFlag, 1'b1);

    // Load-use: exactly one stall, then forward from the wb stage
    step(ri(4'd0, 5'd7, 5'd0, 16'h1234), 1'b0, s);
    step(sw(5'd7, 5'd0, 16'h0010), 1'b0, s);
    step(lw(5'd5, 5'd0, 16'h0010), 1'b0, s);
    step(ri(4'd0, 5'd6, 5'd5, 16'd1), 1'b0, s);
    check("loaduse_stall_cycles", s, 1);
    check("loaduse_result", bus.dmemAdrx, 32'h1235);

    // Flush squashes a store and a register write; also flush during a stall
    step(sw(5'd7, 5'd0, 16'h0020), 1'b1, s);
    check("flush_store", bus.dmemWrite, 1'b0);
    step(rr(4'd0, 5'd14, 5'd7, 5'd7), 1'b1, s);
    step(lw(5'd9, 5'd0, 16'h0010), 1'b0, s);
    step(rr(4'd0, 5'd10, 5'd9, 5'd9), 1'b1, s);
    check("flush_with_stall_we", bus.dmemWrite, 1'b0);

    // r0 write suppression, SLT, shifts, unused op
    step(ri(4'd0, 5'd0, 5'd0, 16'h0033), 1'b0, s);
    step(rr(4'd3, 5'd15, 5'd0, 5'd0), 1'b0, s);
    check("r0_reads_zero", bus.dmemAdrx, 32'd0);
    step(ri(4'd0, 5'd8, 5'd0, 16'hFFFF), 1'b0, s);
    step(ri(4'd0, 5'd9, 5'd0, 16'd1), 1'b0, s);
    step(rr(4'd5, 5'd10, 5'd8, 5'd9), 1'b0, s);
    check("slt_neg", bus.dmemAdrx, 32'd1);
    step(ri(4'd0, 5'd11, 5'd0, 16'd1), 1'b0, s);
    step(ri(4'd6, 5'd11, 5'd11, 16'd31), 1'b0, s);
    check("sll_31", bus.dmemAdrx, 32'h8000_0000);
    step(ri(4'd7, 5'd12, 5'd11, 16'd31), 1'b0, s);
    check("srl_31", bus.dmemAdrx, 32'd1);
    step(rr(4'd12, 5'd16, 5'd1, 5'd2), 1'b0, s);
    check("op12_result", bus.dmemAdrx, 32'd0);
    check("op12_zflag", bus.execZFlag, 1'b1);

    // Mid-stream reset discards the in-flight instruction
    repeat (3) step(nop, 1'b0, s);
    drive(ri(4'd0, 5'd9, 5'd0, 16'h0055), 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(nop, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("midreset_outputs", {bus.dmemAdrx, bus.dmemWrData, bus.dmemWrite, bus.execZFlag,
                               bus.execRfRdData0Short, bus.wbRfWrAdrx, bus.wbRfWrData,
                               bus.wbRfWriteEn, bus.hazardStall}, 128'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    last_ld = 5'd0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_wb_we", bus.wbRfWriteEn, 1'b0);
    check("post_reset_dmem_we", bus.dmemWrite, 1'b0);
    @(posedge clk);
    #1;

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      step(rand_instr(), ($urandom_range(0, 9) == 0), s);
    end

    repeat (4) step(nop, 1'b0, s);
    check("wb_drain", wb_exp.size(), 0);
    check("st_drain", st_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
